tx_link_control_ml: RTL

TX_LINK_CONTROL_ML -- requirements
Module: tx_link_control_ml

---
 rtl/tx_link_control_ml.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/tx_link_control_ml.sv
// Transmit link-layer control FSM: SYNC -> INIT_LANE (ILA) -> DATA_ENC, with per-lane source mux.
// Optional macro TX_LINK_RESYNC_CNT_EN adds o_resync_cnt, a saturating DATA_ENC->SYNC counter.
module tx_link_control_ml #(
    parameter int unsigned NUM_LANES = 4,
    parameter int unsigned ILA_CNT_W = 9
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_frame_clk,
    input  logic                   i_lmfc_clk,
    input  logic                   i_sync_request,
    input  logic [NUM_LANES-1:0]   i_lane_en,
    input  logic                   i_link_test_en,
    input  logic [1:0]             i_link_test_sel,
    input  logic [7:0]             i_F,
    input  logic [7:0]             i_ila_mf_len,
    output logic [3*NUM_LANES-1:0] o_link_mux,
    output logic [1:0]             o_link_test_sel,
    output logic [2:0]             o_state,
    output logic [ILA_CNT_W-1:0]   o_ila_mf_idx,
    output logic                   o_ila_start,
`ifdef TX_LINK_RESYNC_CNT_EN
    output logic                   o_link_up,
    output logic [7:0]             o_resync_cnt
`else
    output logic                   o_link_up
`endif
);

    typedef enum logic [2:0] {
        StSync     = 3'b001,
        StInitLane = 3'b010,
        StDataEnc  = 3'b100
    } state_e;

    localparam logic [2:0] MuxUser = 3'd0;
    localparam logic [2:0] MuxK    = 3'd1;
    localparam logic [2:0] MuxIla  = 3'd2;
    localparam logic [2:0] MuxTest = 3'd3;
    localparam logic [2:0] MuxIdle = 3'd4;

    state_e                 state_q, state_d;
    logic [3:0]             k_cnt_q, k_cnt_d;
    logic [3:0]             k_min;
    logic [ILA_CNT_W-1:0]   ila_cnt_q, ila_cnt_d;
    logic                   ila_last;
    logic                   ila_start_q, ila_start_d;
    logic                   link_up_q, link_up_d;
    logic [1:0]             test_sel_q;
    logic [2:0]             lane_code;
    logic [3*NUM_LANES-1:0] mux_q, mux_d, mux_rst;

    // Minimum K-character frames before ILA, from decoded F = i_F + 1.
    always_comb begin
        if (i_F == 8'd0) begin
            k_min = 4'd10;
        end else if (i_F == 8'd1) begin
            k_min = 4'd6;
        end else if (i_F <= 8'd3) begin
            k_min = 4'd4;
        end else if (i_F <= 8'd7) begin
            k_min = 4'd3;
        end else begin
            k_min = 4'd2;
        end
    end

    assign ila_last = (32'(ila_cnt_q) == 32'(i_ila_mf_len));

    always_comb begin
        state_d   = state_q;
        k_cnt_d   = 4'd0;
        ila_cnt_d = '0;
        unique case (state_q)
            StSync: begin
                if (i_frame_clk && (k_cnt_q != 4'd15)) begin
                    k_cnt_d = k_cnt_q + 4'd1;
                end else begin
                    k_cnt_d = k_cnt_q;
                end
                if (!i_sync_request && i_lmfc_clk && (k_cnt_q >= k_min)) begin
                    state_d = StInitLane;
                    k_cnt_d = 4'd0;
                end
            end
            StInitLane: begin
                // Sync request outranks the final-LMFC transition into DATA_ENC.
                if (i_sync_request) begin
                    state_d = StSync;
                end else if (i_lmfc_clk) begin
                    if (ila_last) begin
                        state_d = StDataEnc;
                    end else begin
                        ila_cnt_d = ila_cnt_q + ILA_CNT_W'(1);
                    end
                end else begin
                    ila_cnt_d = ila_cnt_q;
                end
            end
            StDataEnc: begin
                if (i_sync_request) begin
                    state_d = StSync;
                end
            end
            default: state_d = StSync;
        endcase
    end

    assign ila_start_d = (state_q == StSync) && (state_d == StInitLane);
    assign link_up_d   = (state_d == StDataEnc);

    always_comb begin
        unique case (state_d)
            StSync:     lane_code = MuxK;
            StInitLane: lane_code = MuxIla;
            StDataEnc:  lane_code = i_link_test_en ? MuxTest : MuxUser;
            default:    lane_code = MuxK;
        endcase
    end

    always_comb begin
        mux_d   = '0;
        mux_rst = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            mux_d[3*l +: 3]   = i_lane_en[l] ? lane_code : MuxIdle;
            mux_rst[3*l +: 3] = i_lane_en[l] ? MuxK : MuxIdle;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StSync;
            k_cnt_q     <= 4'd0;
            ila_cnt_q   <= '0;
            ila_start_q <= 1'b0;
            link_up_q   <= 1'b0;
            test_sel_q  <= 2'd0;
            mux_q       <= mux_rst;
        end else begin
            state_q     <= state_d;
            k_cnt_q     <= k_cnt_d;
            ila_cnt_q   <= ila_cnt_d;
            ila_start_q <= ila_start_d;
            link_up_q   <= link_up_d;
            test_sel_q  <= i_link_test_sel;
            mux_q       <= mux_d;
        end
    end

`ifdef TX_LINK_RESYNC_CNT_EN
    logic [7:0] resync_q, resync_d;

    always_comb begin
        resync_d = resync_q;
        if ((state_q == StDataEnc) && (state_d == StSync) && (resync_q != 8'd255)) begin
            resync_d = resync_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            resync_q <= 8'd0;
        end else begin
            resync_q <= resync_d;
        end
    end

    assign o_resync_cnt = resync_q;
`endif

    assign o_state         = state_q;
    assign o_link_mux      = mux_q;
    assign o_ila_mf_idx    = ila_cnt_q;
    assign o_ila_start     = ila_start_q;
    assign o_link_up       = link_up_q;
    assign o_link_test_sel = test_sel_q;

endmodule
